// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x3 matrix keypad scanner.
// Key codes: digits 0-9, '*' = 10, '#' = 11.

package keypad_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDebounce,
    StHeld
  } state_e;

  typedef enum logic [1:0] {
    FrNone,
    FrSingle,
    FrMulti
  } frame_e;

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;

  // Telephone layout: rows 0-2 hold 1..9, row 3 holds *, 0, #.
  function automatic logic [3:0] key_code(input logic [1:0] row_idx, input logic [1:0] col_idx);
    logic [3:0] code;
    code = 4'd0;
    if (row_idx == 2'd3) begin
      case (col_idx)
        2'd0:    code = KEY_STAR;
        2'd1:    code = 4'd0;
        default: code = KEY_HASH;
      endcase
    end else begin
      code = 4'(row_idx) * 4'd3 + 4'(col_idx) + 4'd1;
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the three active-low column return lines.
// Resets to all-ones, matching the pulled-up idle level of the columns.

module keypad_sync (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] d_i,
  output logic [2:0] q_o
);

  logic [2:0] meta_q;
  logic [2:0] sync_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q <= 3'b111;
      sync_q <= 3'b111;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 keypad scanner: row drive, per-frame column evaluation, debounce FSM and
// one-cycle key strobes. Define KEYPAD_SYNC_EN to synchronize the columns first.

module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 16,
  parameter int unsigned DEBOUNCE_CNT = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] col_i,
  output logic [3:0] row_o,
  output logic [3:0] key_o,
  output logic       shift_o,
  output logic       star_o,
  output logic       hash_o,
  output logic       key_held_o
);

  localparam int unsigned PreW = $clog2(SCAN_DIV);
  localparam int unsigned CntW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [PreW-1:0] PreLast = PreW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(DEBOUNCE_CNT);

  // Column source
  logic [2:0] col_s;

`ifdef KEYPAD_SYNC_EN
  keypad_sync u_sync (
    .clock (clock),
    .reset (reset),
    .d_i   (col_i),
    .q_o   (col_s)
  );
`else
  assign col_s = col_i;
`endif

  // Row scanning
  logic [PreW-1:0] presc_q, presc_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0]      row_q, row_d;
  logic            slot_end;
  logic            frame_end;

  assign slot_end  = (presc_q == PreLast);
  assign frame_end = slot_end && (idx_q == 2'd3);

  always_comb begin
    presc_d = slot_end ? '0 : presc_q + PreW'(1);
    idx_d   = slot_end ? idx_q + 2'd1 : idx_q;
    row_d   = ~(4'b0001 << idx_d);
  end

  // Per-slot column evaluation and frame accumulation
  logic [2:0] low;
  logic [1:0] slot_hits;
  logic [1:0] slot_col;
  logic [3:0] slot_code;
  logic [1:0] hits_q, hits_d;
  logic [2:0] hits_sum;
  logic [1:0] hits_sat;
  logic [3:0] code_q, code_d;
  logic [3:0] code_acc;
  frame_e     frame_res;

  assign low = ~col_s;

  always_comb begin
    slot_hits = {1'b0, low[0]} + {1'b0, low[1]} + {1'b0, low[2]};
    if (low[0]) begin
      slot_col = 2'd0;
    end else if (low[1]) begin
      slot_col = 2'd1;
    end else begin
      slot_col = 2'd2;
    end
    slot_code = key_code(idx_q, slot_col);
    hits_sum  = {1'b0, hits_q} + {1'b0, slot_hits};
    // Saturate at two: anything beyond one hit is already MULTI.
    hits_sat  = (hits_sum >= 3'd2) ? 2'd2 : hits_sum[1:0];
    code_acc  = (slot_hits == 2'd1) ? slot_code : code_q;

    hits_d = hits_q;
    code_d = code_q;
    if (slot_end) begin
      hits_d = (idx_q == 2'd3) ? 2'd0 : hits_sat;
      code_d = code_acc;
    end

    // Frame result includes the sample taken in the frame-end cycle itself.
    case (hits_sat)
      2'd0:    frame_res = FrNone;
      2'd1:    frame_res = FrSingle;
      default: frame_res = FrMulti;
    endcase
  end

  // Debounce / hold FSM
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      cand_q, cand_d;
  logic [3:0]      key_q, key_d;
  logic            shift_q, shift_d;
  logic            star_q, star_d;
  logic            hash_q, hash_d;
  logic            held_q, held_d;
  logic            accept;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    key_d   = key_q;
    shift_d = 1'b0;
    star_d  = 1'b0;
    hash_d  = 1'b0;
    accept  = 1'b0;

    if (frame_end) begin
      unique case (state_q)
        StIdle: begin
          if (frame_res == FrSingle) begin
            cand_d = code_acc;
            if (CntMax == CntW'(1)) begin
              accept  = 1'b1;
              state_d = StHeld;
              cnt_d   = '0;
            end else begin
              state_d = StDebounce;
              cnt_d   = CntW'(1);
            end
          end
        end
        StDebounce: begin
          if (frame_res == FrSingle && code_acc == cand_q) begin
            if (cnt_q + CntW'(1) == CntMax) begin
              accept  = 1'b1;
              state_d = StHeld;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end else begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        end
        StHeld: begin
          // MULTI counts toward release just like NONE.
          if (frame_res != FrSingle) begin
            if (cnt_q + CntW'(1) == CntMax) begin
              state_d = StIdle;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end else begin
            cnt_d = '0;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end

    if (accept) begin
      key_d = code_acc;
      if (code_acc == KEY_STAR) begin
        star_d = 1'b1;
      end else if (code_acc == KEY_HASH) begin
        hash_d = 1'b1;
      end else begin
        shift_d = 1'b1;
      end
    end

    held_d = (state_d == StHeld);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      idx_q   <= 2'd0;
      row_q   <= 4'b1110;
      hits_q  <= 2'd0;
      code_q  <= 4'd0;
      state_q <= StIdle;
      cnt_q   <= '0;
      cand_q  <= 4'd0;
      key_q   <= 4'd0;
      shift_q <= 1'b0;
      star_q  <= 1'b0;
      hash_q  <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      row_q   <= row_d;
      hits_q  <= hits_d;
      code_q  <= code_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      key_q   <= key_d;
      shift_q <= shift_d;
      star_q  <= star_d;
      hash_q  <= hash_d;
      held_q  <= held_d;
    end
  end

  assign row_o      = row_q;
  assign key_o      = key_q;
  assign shift_o    = shift_q;
  assign star_o     = star_q;
  assign hash_o     = hash_q;
  assign key_held_o = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: emulated key matrix, directed scenarios then random
// frame-aligned presses, checked against a frame-level keypad model.

module tb_keypad_scanner;

  localparam int ScanDiv  = 4;
  localparam int DebCnt   = 3;
  localparam int FrameLen = 4 * ScanDiv;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] col;
  logic [3:0] row;
  logic [3:0] key;
  logic       shift, star, hash, key_held;

  // Pressed keys, bit index = row * 3 + column.
  logic [11:0] pressed = '0;

  int nchk = 0;
  int nfail = 0;
  int cyc = 0;

  int keymap [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 11};

  // Model state
  int m_key  = 0;
  int m_held = 0;
  int m_cand = 0;
  int m_run  = 0;
  int m_rel  = 0;

  keypad_scanner #(
    .SCAN_DIV     (ScanDiv),
    .DEBOUNCE_CNT (DebCnt)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .col_i      (col),
    .row_o      (row),
    .key_o      (key),
    .shift_o    (shift),
    .star_o     (star),
    .hash_o     (hash),
    .key_held_o (key_held)
  );

  always #5 clock = ~clock;

  // A pressed key shorts its row to its column.
  always_comb begin
    col = 3'b111;
    for (int r = 0; r < 4; r++) begin
      if (!row[r]) col = col & ~pressed[r*3 +: 3];
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  // One frame of keypad behaviour; pulse: 0 none, 1 shift, 2 star, 3 hash.
  task automatic model_frame(input logic [11:0] m, output int pulse);
    int k;
    k = -1;
    pulse = 0;
    if ($countones(m) == 1) begin
      for (int i = 0; i < 12; i++) if (m[i]) k = keymap[i];
    end
    if (m_held != 0) begin
      if (k < 0) begin
        m_rel++;
        if (m_rel == DebCnt) begin
          m_held = 0;
          m_rel  = 0;
        end
      end else begin
        m_rel = 0;
      end
    end else if (k >= 0 && (m_run == 0 || k == m_cand)) begin
      if (m_run == 0) m_cand = k;
      m_run++;
      if (m_run == DebCnt) begin
        m_held = 1;
        m_run  = 0;
        m_key  = k;
        pulse  = (k == 10) ? 2 : (k == 11) ? 3 : 1;
      end
    end else begin
      m_run = 0;
    end
  endtask

  // Hold mask m for ncyc cycles starting at a frame boundary.
  task automatic run_frame(input logic [11:0] m, input int ncyc);
    int   pulse;
    bit   last;
    logic [3:0] er;
    pressed = m;
    pulse = 0;
    if (ncyc == FrameLen) model_frame(m, pulse);
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clock);
      #1;
      cyc++;
      last = (i == FrameLen - 1);
      er = ~(4'b0001 << ((cyc / ScanDiv) % 4));
      check("row", int'(row), int'(er));
      check("shift", int'(shift), int'(last && pulse == 1));
      check("star", int'(star), int'(last && pulse == 2));
      check("hash", int'(hash), int'(last && pulse == 3));
      if (last) begin
        check("key", int'(key), m_key);
        check("key_held", int'(key_held), m_held);
      end
    end
  endtask

  task automatic apply_reset();
    #2 reset = 1'b1;
    #1;
    check("rst_row", int'(row), 14);
    check("rst_key", int'(key), 0);
    check("rst_shift", int'(shift), 0);
    check("rst_star", int'(star), 0);
    check("rst_hash", int'(hash), 0);
    check("rst_held", int'(key_held), 0);
    pressed = '0;
    @(negedge clock);
    reset  = 1'b0;
    cyc    = 0;
    m_key  = 0;
    m_held = 0;
    m_cand = 0;
    m_run  = 0;
    m_rel  = 0;
  endtask

  initial begin
    apply_reset();

    // Idle scanning
    repeat (2) run_frame(12'h000, FrameLen);

    // Key 5 held for five frames, then released
    repeat (5) run_frame(12'h010, FrameLen);
    repeat (4) run_frame(12'h000, FrameLen);

    // Bouncing 7 never reaches three stable frames
    repeat (2) run_frame(12'h040, FrameLen);
    run_frame(12'h000, FrameLen);
    repeat (2) run_frame(12'h040, FrameLen);
    repeat (2) run_frame(12'h000, FrameLen);

    // Star then hash
    repeat (3) run_frame(12'h200, FrameLen);
    repeat (3) run_frame(12'h000, FrameLen);
    repeat (3) run_frame(12'h800, FrameLen);
    repeat (3) run_frame(12'h000, FrameLen);

    // 1 and 9 together
    repeat (6) run_frame(12'h101, FrameLen);
    run_frame(12'h000, FrameLen);

    // 3 held, then 2 added
    repeat (3) run_frame(12'h004, FrameLen);
    repeat (2) run_frame(12'h006, FrameLen);
    repeat (3) run_frame(12'h000, FrameLen);

    // Reset while debouncing
    run_frame(12'h010, FrameLen);
    run_frame(12'h010, 7);
    apply_reset();
    repeat (2) run_frame(12'h000, FrameLen);

    // Reset while held
    repeat (3) run_frame(12'h020, FrameLen);
    run_frame(12'h020, 9);
    apply_reset();
    repeat (2) run_frame(12'h000, FrameLen);

    // Random runs of none / single / multi presses
    for (int n = 0; n < 60; n++) begin
      int sel;
      int rep;
      int a;
      int b;
      logic [11:0] m;
      sel = int'($urandom_range(0, 9));
      rep = int'($urandom_range(1, 5));
      a   = int'($urandom_range(0, 11));
      b   = (a + int'($urandom_range(1, 11))) % 12;
      m   = '0;
      if (sel >= 3) m[a] = 1'b1;
      if (sel >= 8) m[b] = 1'b1;
      repeat (rep) run_frame(m, FrameLen);
    end
    repeat (4) run_frame(12'h000, FrameLen);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x3 telephone-style matrix keypad, debounces presses and converts each accepted key into a 4-bit code. It sits directly upstream of the alarm clock's four-digit key shift register and feeds its `key` and `shift` inputs. It also emits separate one-cycle strobes for the `*` and `#` keys, which the control FSM uses as command keys.

## Interface
- `SCAN_DIV`, default 16: clocks each row is driven per slot; must be ≥ 4.
- `DEBOUNCE_CNT`, default 4: consecutive identical scan frames required to accept a press or a release; must be ≥ 1.
- `clock` input 1: system clock.
- `reset` input 1: asynchronous, active-high.
- `col` input 3: column return lines, active-low (pulled up); `col[0]` is the leftmost column.
- `row` output 4: row drive lines, active-low, exactly one row low at any time.
- `key` output 4: code of the last accepted key (0–9; `*`=10; `#`=11).
- `shift` output 1: one-cycle pulse when a digit key 0–9 is accepted.
- `star` output 1: one-cycle pulse when `*` is accepted.
- `hash` output 1: one-cycle pulse when `#` is accepted.
- `key_held` output 1: high while an accepted key has not yet been released.

## Operation
- Key map by (row, col[0..2]):
  - row0 = 1, 2, 3
  - row1 = 4, 5, 6
  - row2 = 7, 8, 9
  - row3 = `*`, 0, `#`
- Scanning:
  - A prescaler counts 0..SCAN_DIV-1 per slot.
  - The row index advances 0→1→2→3→0 at the end of each slot.
  - `row` = ~(1 << index).
- Column sampling:
  - Columns are sampled on the last prescaler cycle of each slot.
  - A frame is four slots; the result is evaluated at the end of row3's slot.
- Frame result:
  - NONE if no low columns in any row.
  - SINGLE(code) if exactly one row/column intersection is low.
  - MULTI otherwise. MULTI is treated as NONE.
- FSM states:
  - IDLE: on SINGLE(K), latch candidate K, stable count = 1, go to DEBOUNCE. If DEBOUNCE_CNT = 1, accept immediately instead.
  - DEBOUNCE:
    - SINGLE(same K): count increments; at count = DEBOUNCE_CNT, accept and go to HELD.
    - Any other result: go to IDLE, count = 0.
  - HELD: `key_held` = 1. Count consecutive NONE frames; at DEBOUNCE_CNT go to IDLE. Any non-NONE frame clears the release count. A new key pressed while held is ignored until full release.
- Accept action:
  - `key` ← K.
  - Exactly one of `shift`/`star`/`hash` pulses high for one cycle, on the cycle after the accepting frame end.
  - `key` is stable from that same cycle and holds until the next accept.
- Reset values:
  - `row` = 4'b1110; `key` = 0.
  - `shift`, `star`, `hash`, `key_held` = 0.
  - State IDLE; prescaler, row index and all counters = 0.
- Reset mid-operation aborts any debounce or held state; there is no pulse on reset release.

## Timing
- Frame length = 4·SCAN_DIV cycles.
- Press-to-pulse latency, from the first frame that sees the key:
  - (DEBOUNCE_CNT−1) further frames;
  - plus 1 cycle after that frame's end.
- Release-to-IDLE: DEBOUNCE_CNT NONE frames.
- Column settle time: SCAN_DIV−1 cycles after a row change before sampling.
- `row` is registered; strobes are registered, glitch-free one-cycle pulses.
- Simultaneous events:
  - A frame end coincides with the row index wrap; evaluate using the sample taken in that same cycle.
  - At most one accept per key press; auto-repeat never occurs.

## Configuration
- `KEYPAD_SYNC_EN` defined:
  - `col` passes through a two-flop synchronizer before sampling.
  - The sample point stays the last slot cycle, so the effective settle time is SCAN_DIV−3 cycles.
  - Externally visible latency is unchanged.
- Undefined: `col` is sampled directly (for already-synchronous sources and simulation).

## Structure
- Shared package `keypad_pkg`:
  - FSM state enum (IDLE, DEBOUNCE, HELD).
  - Constants KEY_STAR = 4'd10 and KEY_HASH = 4'd11.
  - Frame-result encoding (NONE/SINGLE/MULTI).
- Sub-module `keypad_sync`: a 3-bit two-flop synchronizer, instantiated only under `KEYPAD_SYNC_EN`.
- Everything else stays in one module.

## Test plan
All scenarios use SCAN_DIV = 4 and DEBOUNCE_CNT = 3, so a frame is 16 cycles.
- Reset, then idle: `row` cycles 1110→1101→1011→0111 every 4 cycles; no strobes; `key` = 0.
- Hold key "5" (row1/col1 low) for 5 frames, then release:
  - exactly one `shift` pulse, `key` = 5, 1 cycle after the 3rd frame end;
  - `key_held` drops after 3 NONE frames.
- Bounce "7" for 2 frames, release 1 frame, press 2 frames: no strobe, `key` unchanged.
- Press `*`, then `#` (separate, fully released): `star` pulse with `key` = 10, then `hash` pulse with `key` = 11; `shift` never asserted.
- Press "1" and "9" simultaneously (MULTI) for 6 frames: no strobe. While "3" is held, also press "2": only "3" is accepted.
- Assert `reset` during DEBOUNCE and during HELD: outputs return to reset values immediately; no pulse after deassertion.
